flit_requester: RTL
===================

FLIT_REQUESTER -- requirements
Module: flit_requester

Interface
REQ-001 Parameter FW, default 32, flit width in bits.
REQ-002 Parameter DEPTH, default 4, input FIFO depth in flits; power of 2, at least 2.
REQ-003 Parameter NOUT, default 3, number of output ports arbitrated; matches arbiter LEN.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream flit valid.
REQ-007 in_ready  output  1  FIFO can accept a flit.
REQ-008 in_flit  input  FW  upstream flit.
REQ-009 request  output  NOUT  one-hot request to arbiter for routed output.
REQ-010 grant  input  NOUT  arbiter grant; combinational from request.
REQ-011 update  output  1  arbiter priority-update strobe.
REQ-012 out_valid  output  1  flit presented to granted output.
REQ-013 out_ready  input  1  downstream accepts flit.
REQ-014 out_flit  output  FW  FIFO head flit.
REQ-015 err_drop  output  1  one-cycle pulse per discarded flit.

Function
REQ-016 Flit type is in_flit[FW-1:FW-2]: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head and tail); destination port index is flit[3:0], valid only on head/single.
REQ-017 FIFO: push when in_valid & in_ready; in_ready = not full; no bypass, so push to a full FIFO is refused even if a pop occurs that cycle.
REQ-018 Simultaneous push and pop when non-full and non-empty: count unchanged, both pointers advance and wrap modulo DEPTH.
REQ-019 FSM states IDLE, REQ, DROP; reset state IDLE.
REQ-020 IDLE, FIFO empty: stay IDLE, request = 0.
REQ-021 IDLE, head is head/single with dest < NOUT: latch dest into route register; next state REQ.
REQ-022 IDLE, head is head/single with dest >= NOUT: next state DROP.
REQ-023 IDLE, head is body/tail (orphan): pop it without output; pulse err_drop; stay IDLE.
REQ-024 REQ: request = one-hot(route), held every cycle including while FIFO is empty mid-packet (wormhole lock).
REQ-025 REQ: out_valid = FIFO not empty & grant[route]; pop and transfer when out_valid & out_ready.
REQ-026 Transfer of a tail or single flit in REQ: update = 1 in that cycle only; next state IDLE; request = 0 from next cycle.
REQ-027 update is 0 in every other cycle; grant bits other than grant[route] are ignored.
REQ-028 DROP: pop one flit per cycle when FIFO not empty; pulse err_drop per pop; out_valid = 0, request = 0; popping a tail or single flit returns to IDLE.
REQ-029 Latency: a head pushed at cycle N appears at the FIFO head at N+1; request asserts at N+2; the first transfer occurs no earlier than N+2.
REQ-030 out_flit is the FIFO head entry regardless of out_valid.

Reset
REQ-031 On rst: FIFO empty, pointers/count 0, state IDLE, route 0, in_ready = 1 after release, request = 0, update = 0, out_valid = 0, err_drop = 0.
REQ-032 rst asserted mid-packet discards buffered flits and drops request immediately (asynchronous); no update is issued.

Verification
REQ-033 Push single flit dest 1, grant = 3'b010 held, out_ready = 1 -> request = 3'b010 at cycle 2, transfer plus update = 1 at cycle 2, request = 0 at cycle 3.
REQ-034 Push head(dest 2), body, tail; grant[2] low 3 cycles then high -> request = 3'b100 held throughout, 3 transfers, update only with tail.
REQ-035 Push 4 flits with out_ready = 0 -> in_ready = 0 after 4th push; 5th push refused; pop-and-push in same cycle then accepts nothing until next cycle.
REQ-036 Head dest 5 with NOUT = 3, then body, tail -> 3 err_drop pulses, request = 0, out_valid = 0, state returns IDLE.
REQ-037 Orphan body flit at IDLE -> one err_drop pulse, no request; following valid head is routed normally.
REQ-038 rst pulse after head and body transferred -> request = 0 asynchronously, in_ready = 1, FIFO empty, no update.

Source files
------------

// File: rtl/flit_requester.sv
// -----------------------------------------------------------------------------
// flit_requester
//
// Buffers an incoming wormhole flit stream in a small FIFO. For each packet it
// asks an external arbiter for the output port named in the head flit. Once
// that port is granted, the packet's flits are forwarded to it. Packets that
// name a port that does not exist, and body/tail flits that arrive with no
// head, are discarded, and each discarded flit is flagged.
//
// Flit format: [FW-1:FW-2] type (01 head, 00 body, 10 tail, 11 single),
//              [3:0] destination port (meaningful on head/single only).
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   upstream flit valid
//   in_ready   FIFO can accept a flit (not full)
//   in_flit    upstream flit
//   request    one-hot arbiter request for the routed output
//   grant      arbiter grant (combinational from request)
//   update     arbiter priority-update strobe, with the packet's last flit
//   out_valid  head flit presented to the granted output
//   out_ready  downstream accepts the flit
//   out_flit   FIFO head entry (always driven, qualified by out_valid)
//   err_drop   one-cycle pulse per discarded flit
// -----------------------------------------------------------------------------
module flit_requester #(
    parameter int FW    = 32,
    parameter int DEPTH = 4,
    parameter int NOUT  = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FW-1:0]   in_flit,
    output logic [NOUT-1:0] request,
    input  logic [NOUT-1:0] grant,
    output logic            update,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FW-1:0]   out_flit,
    output logic            err_drop
);

    localparam int          AW     = $clog2(DEPTH);
    localparam int unsigned NOUT_U = NOUT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state;
    logic [3:0]      route;

    logic [FW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            transfer;
    logic            drop_pop;
    logic [1:0]      head_type;
    logic [3:0]      head_dest;
    logic            dest_ok;

    // ---------------------------------------------------------------------
    // FIFO status and head decode
    // ---------------------------------------------------------------------
    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    // A slot freed by a pop this cycle is not visible to the writer until
    // the next cycle, so a full FIFO never accepts a flit.
    assign in_ready  = !full;
    assign push      = in_valid && !full;

    assign out_flit  = mem[rd_ptr];
    assign head_type = out_flit[FW-1:FW-2];
    assign head_dest = out_flit[3:0];
    assign dest_ok   = (32'(head_dest) < NOUT_U);

    // ---------------------------------------------------------------------
    // Output decode. request follows the state/route registers, so it is
    // held for the whole packet even while the FIFO runs dry (wormhole lock)
    // and drops as soon as reset asserts.
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise a missing branch infers a latch.
        request  = '0;
        if (state == REQ) begin
            request = NOUT'(1) << route;
        end
    end

    // request is one-hot on route, so this selects grant[route] only.
    assign out_valid = (state == REQ) && !empty && |(grant & request);
    assign transfer  = out_valid && out_ready;
    assign update    = transfer && head_type[1];

    // Discards: an orphan body/tail seen in IDLE, or any flit while in DROP.
    assign drop_pop  = !empty && (((state == IDLE) && !head_type[0]) || (state == DROP));
    assign err_drop  = drop_pop;
    assign pop       = transfer || drop_pop;

    // ---------------------------------------------------------------------
    // FIFO pointers and occupancy
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only
    // read once written, and count/pointers define which ones are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_flit;
    end

    // ---------------------------------------------------------------------
    // Packet FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            route <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty && head_type[0]) begin
                        if (dest_ok) begin
                            route <= head_dest;
                            state <= REQ;
                        end else begin
                            state <= DROP;
                        end
                    end
                end
                REQ: begin
                    if (transfer && head_type[1]) state <= IDLE;
                end
                DROP: begin
                    if (drop_pop && head_type[1]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
